// File: rtl/axil_pkg.sv
// Shared AXI4-Lite definitions for the register slave: response codes and FSM state types.
package axil_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic {
        W_IDLE,
        W_RESP
    } wr_state_e;

    typedef enum logic {
        R_IDLE,
        R_DATA
    } rd_state_e;

endpackage

// File: rtl/axil_reg_slave_if.sv
// AXI4-Lite bus bundle with master and slave views.
interface axil_reg_slave_if #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned STRB_WIDTH = DATA_WIDTH / 8
);

    logic [ADDR_WIDTH-1:0] awaddr;
    logic [2:0]            awprot;
    logic                  awvalid;
    logic                  awready;

    logic [DATA_WIDTH-1:0] wdata;
    logic [STRB_WIDTH-1:0] wstrb;
    logic                  wvalid;
    logic                  wready;

    logic [1:0]            bresp;
    logic                  bvalid;
    logic                  bready;

    logic [ADDR_WIDTH-1:0] araddr;
    logic [2:0]            arprot;
    logic                  arvalid;
    logic                  arready;

    logic [DATA_WIDTH-1:0] rdata;
    logic [1:0]            rresp;
    logic                  rvalid;
    logic                  rready;

    modport master (
        output awaddr, awprot, awvalid,
        input  awready,
        output wdata, wstrb, wvalid,
        input  wready,
        input  bresp, bvalid,
        output bready,
        output araddr, arprot, arvalid,
        input  arready,
        input  rdata, rresp, rvalid,
        output rready
    );

    modport slave (
        input  awaddr, awprot, awvalid,
        output awready,
        input  wdata, wstrb, wvalid,
        output wready,
        output bresp, bvalid,
        input  bready,
        input  araddr, arprot, arvalid,
        output arready,
        output rdata, rresp, rvalid,
        input  rready
    );

endinterface

// File: rtl/axil_reg_bank.sv
// Register array with one byte-strobed write port and one combinational read port.
module axil_reg_bank #(
    parameter int unsigned NUM_REGS   = 16,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned IDX_WIDTH  = $clog2(NUM_REGS)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    wr_en,
    input  logic [IDX_WIDTH-1:0]    wr_idx,
    input  logic [DATA_WIDTH-1:0]   wr_data,
    input  logic [DATA_WIDTH/8-1:0] wr_strb,
    input  logic [IDX_WIDTH-1:0]    rd_idx,
    output logic [DATA_WIDTH-1:0]   rd_data
);

    logic [DATA_WIDTH-1:0] regs [NUM_REGS];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(NUM_REGS); i++) begin
                regs[i] <= '0;
            end
        end else if (wr_en) begin
            for (int k = 0; k < int'(DATA_WIDTH / 8); k++) begin
                if (wr_strb[k]) begin
                    regs[wr_idx][8*k +: 8] <= wr_data[8*k +: 8];
                end
            end
        end
    end

    // Read sees the array before any same-edge write lands.
    assign rd_data = regs[rd_idx];

endmodule

// File: rtl/axil_reg_slave.sv
// AXI4-Lite register slave: independent write and read FSMs in front of a register bank.
module axil_reg_slave
    import axil_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned STRB_WIDTH = DATA_WIDTH / 8,
    parameter int unsigned NUM_REGS   = 16
) (
    input  logic             clk,
    input  logic             rst,
    axil_reg_slave_if.slave  s_axil
);

    localparam int unsigned IDX_WIDTH = $clog2(NUM_REGS);
    localparam int unsigned WORD_WIDTH = ADDR_WIDTH - 2;
    localparam logic [WORD_WIDTH-1:0] REG_LIMIT = WORD_WIDTH'(NUM_REGS);

    wr_state_e             wr_state_q, wr_state_d;
    rd_state_e             rd_state_q, rd_state_d;
    logic                  wr_hs, rd_hs;
    logic [1:0]            bresp_q, bresp_d;
    logic [1:0]            rresp_q, rresp_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;

    logic [WORD_WIDTH-1:0] wr_word, rd_word;
    logic                  wr_in_range, rd_in_range;
    logic [DATA_WIDTH-1:0] bank_rd_data;

    assign wr_word     = s_axil.awaddr[ADDR_WIDTH-1:2];
    assign rd_word     = s_axil.araddr[ADDR_WIDTH-1:2];
    assign wr_in_range = wr_word < REG_LIMIT;
    assign rd_in_range = rd_word < REG_LIMIT;

    // Byte offset and protection bits carry no meaning for this slave.
    logic unused_bits;
    assign unused_bits = ^{s_axil.awprot, s_axil.arprot, s_axil.awaddr[1:0], s_axil.araddr[1:0]};

    axil_reg_bank #(
        .NUM_REGS   (NUM_REGS),
        .DATA_WIDTH (DATA_WIDTH),
        .IDX_WIDTH  (IDX_WIDTH)
    ) u_bank (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr_hs && wr_in_range),
        .wr_idx  (wr_word[IDX_WIDTH-1:0]),
        .wr_data (s_axil.wdata),
        .wr_strb (s_axil.wstrb),
        .rd_idx  (rd_word[IDX_WIDTH-1:0]),
        .rd_data (bank_rd_data)
    );

    // Write channel: address and data are only ever accepted together.
    always_comb begin
        wr_state_d = wr_state_q;
        wr_hs      = 1'b0;
        bresp_d    = bresp_q;
        case (wr_state_q)
            W_IDLE: begin
                if (!rst && s_axil.awvalid && s_axil.wvalid) begin
                    wr_hs      = 1'b1;
                    bresp_d    = wr_in_range ? RESP_OKAY : RESP_SLVERR;
                    wr_state_d = W_RESP;
                end
            end
            W_RESP: begin
                if (s_axil.bready) begin
                    wr_state_d = W_IDLE;
                end
            end
        endcase
    end

    always_comb begin
        rd_state_d = rd_state_q;
        rd_hs      = 1'b0;
        rresp_d    = rresp_q;
        rdata_d    = rdata_q;
        case (rd_state_q)
            R_IDLE: begin
                if (!rst && s_axil.arvalid) begin
                    rd_hs      = 1'b1;
                    rresp_d    = rd_in_range ? RESP_OKAY : RESP_SLVERR;
                    rdata_d    = rd_in_range ? bank_rd_data : '0;
                    rd_state_d = R_DATA;
                end
            end
            R_DATA: begin
                if (s_axil.rready) begin
                    rd_state_d = R_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_state_q <= W_IDLE;
            rd_state_q <= R_IDLE;
            bresp_q    <= RESP_OKAY;
            rresp_q    <= RESP_OKAY;
            rdata_q    <= '0;
        end else begin
            wr_state_q <= wr_state_d;
            rd_state_q <= rd_state_d;
            bresp_q    <= bresp_d;
            rresp_q    <= rresp_d;
            rdata_q    <= rdata_d;
        end
    end

    assign s_axil.awready = wr_hs;
    assign s_axil.wready  = wr_hs;
    assign s_axil.bvalid  = (wr_state_q == W_RESP);
    assign s_axil.bresp   = bresp_q;
    assign s_axil.arready = rd_hs;
    assign s_axil.rvalid  = (rd_state_q == R_DATA);
    assign s_axil.rdata   = rdata_q;
    assign s_axil.rresp   = rresp_q;

    // Responses stay up and steady until the master takes them.
    assert property (@(posedge clk) disable iff (rst)
        s_axil.bvalid && !s_axil.bready |=> s_axil.bvalid && $stable(s_axil.bresp));
    assert property (@(posedge clk) disable iff (rst)
        s_axil.rvalid && !s_axil.rready |=>
            s_axil.rvalid && $stable(s_axil.rdata) && $stable(s_axil.rresp));
    assert property (@(posedge clk) disable iff (rst)
        !(s_axil.awready && s_axil.bvalid));

endmodule

// File: tb/tb_axil_reg_slave.sv
// Self-checking bench for axil_reg_slave against an array-based register model.
module tb_axil_reg_slave;
    import axil_pkg::*;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int SW = 4;
    localparam int NR = 16;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    axil_reg_slave_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .STRB_WIDTH(SW)) bus ();

    axil_reg_slave #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .STRB_WIDTH (SW),
        .NUM_REGS   (NR)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .s_axil (bus)
    );

    int passed = 0;
    int total  = 0;
    logic [31:0] model [NR];

    function automatic int word_of(input logic [31:0] addr);
        return int'(addr >> 2);
    endfunction

    function automatic logic [1:0] exp_resp(input logic [31:0] addr);
        return (word_of(addr) < NR) ? 2'b00 : 2'b10;
    endfunction

    function automatic logic [31:0] exp_rdata(input logic [31:0] addr);
        return (word_of(addr) < NR) ? model[word_of(addr)] : 32'h0;
    endfunction

    task automatic model_write(input logic [31:0] addr, input logic [31:0] data,
                               input logic [3:0] strb);
        int w;
        w = word_of(addr);
        if (w < NR) begin
            for (int k = 0; k < 4; k++) begin
                if (strb[k]) model[w][8*k +: 8] = data[8*k +: 8];
            end
        end
    endtask

    task automatic idle_bus();
        bus.awaddr = '0; bus.awprot = '0; bus.awvalid = 1'b0;
        bus.wdata = '0; bus.wstrb = '0; bus.wvalid = 1'b0;
        bus.bready = 1'b0;
        bus.araddr = '0; bus.arprot = '0; bus.arvalid = 1'b0;
        bus.rready = 1'b0;
    endtask

    task automatic axi_write(input logic [31:0] addr, input logic [31:0] data,
                             input logic [3:0] strb, output logic [1:0] resp, output bit ok);
        int n;
        ok = 1'b1;
        resp = 2'bxx;
        @(negedge clk);
        bus.awaddr = addr; bus.awprot = 3'($urandom); bus.awvalid = 1'b1;
        bus.wdata = data; bus.wstrb = strb; bus.wvalid = 1'b1;
        bus.bready = 1'b1;
        n = 0;
        #1;
        while (!(bus.awready && bus.wready)) begin
            n++;
            if (n > 20) begin
                ok = 1'b0;
                bus.awvalid = 1'b0; bus.wvalid = 1'b0; bus.bready = 1'b0;
                return;
            end
            @(negedge clk);
            #1;
        end
        @(posedge clk);
        #1;
        bus.awvalid = 1'b0; bus.wvalid = 1'b0;
        n = 0;
        @(negedge clk);
        while (!bus.bvalid) begin
            n++;
            if (n > 20) begin
                ok = 1'b0;
                bus.bready = 1'b0;
                return;
            end
            @(negedge clk);
        end
        resp = bus.bresp;
        @(posedge clk);
        #1;
        bus.bready = 1'b0;
    endtask

    task automatic axi_read(input logic [31:0] addr, output logic [31:0] data,
                            output logic [1:0] resp, output int lat, output bit ok);
        int n;
        ok = 1'b1;
        data = 'x; resp = 2'bxx; lat = -1;
        @(negedge clk);
        bus.araddr = addr; bus.arprot = 3'($urandom); bus.arvalid = 1'b1;
        bus.rready = 1'b1;
        n = 0;
        #1;
        while (!bus.arready) begin
            n++;
            if (n > 20) begin
                ok = 1'b0;
                bus.arvalid = 1'b0; bus.rready = 1'b0;
                return;
            end
            @(negedge clk);
            #1;
        end
        @(posedge clk);
        #1;
        bus.arvalid = 1'b0;
        n = 1;
        @(negedge clk);
        while (!bus.rvalid) begin
            n++;
            if (n > 20) begin
                ok = 1'b0;
                bus.rready = 1'b0;
                return;
            end
            @(negedge clk);
        end
        lat = n;
        data = bus.rdata; resp = bus.rresp;
        @(posedge clk);
        #1;
        bus.rready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle_bus();
        bus.awvalid = 1'b1; bus.wvalid = 1'b1; bus.arvalid = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        total++;
        if ({bus.awready, bus.wready, bus.arready} !== 3'b000)
            $display("FAIL reset_readies: got %b want 000", {bus.awready, bus.wready, bus.arready});
        else passed++;
        total++;
        if ({bus.bvalid, bus.rvalid} !== 2'b00)
            $display("FAIL reset_valids: got %b want 00", {bus.bvalid, bus.rvalid});
        else passed++;
        total++;
        if ({bus.bresp, bus.rresp} !== 4'b0000 || bus.rdata !== 32'h0)
            $display("FAIL reset_resp_data: bresp=%b rresp=%b rdata=%h want 00 00 0",
                     bus.bresp, bus.rresp, bus.rdata);
        else passed++;
        idle_bus();
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < NR; i++) model[i] = 32'h0;
    endtask

    task automatic test_basic();
        logic [1:0] resp; logic [31:0] data; int lat; bit ok;
        axi_write(32'h08, 32'hDEADBEEF, 4'hF, resp, ok);
        model_write(32'h08, 32'hDEADBEEF, 4'hF);
        total++;
        if (!ok || resp !== 2'b00) $display("FAIL basic_bresp: ok=%0d got %b want 00", ok, resp);
        else passed++;
        axi_read(32'h08, data, resp, lat, ok);
        total++;
        if (!ok || data !== 32'hDEADBEEF || resp !== 2'b00)
            $display("FAIL basic_read: ok=%0d got %h/%b want deadbeef/00", ok, data, resp);
        else passed++;
        total++;
        if (lat !== 1) $display("FAIL basic_latency: got %0d want 1", lat);
        else passed++;
    endtask

    task automatic test_strobes();
        logic [1:0] resp; logic [31:0] data; int lat; bit ok;
        axi_write(32'h04, 32'hFFFFFFFF, 4'hF, resp, ok);
        model_write(32'h04, 32'hFFFFFFFF, 4'hF);
        axi_write(32'h04, 32'h12345678, 4'h5, resp, ok);
        model_write(32'h04, 32'h12345678, 4'h5);
        axi_read(32'h04, data, resp, lat, ok);
        total++;
        if (!ok || data !== 32'hFF34FF78 || resp !== 2'b00)
            $display("FAIL strobe_read: ok=%0d got %h/%b want ff34ff78/00", ok, data, resp);
        else passed++;
        axi_write(32'h04, 32'h0, 4'h0, resp, ok);
        axi_read(32'h04, data, resp, lat, ok);
        total++;
        if (!ok || data !== 32'hFF34FF78) $display("FAIL zero_strobe: got %h want ff34ff78", data);
        else passed++;
    endtask

    task automatic test_out_of_range();
        logic [1:0] resp; logic [31:0] data; int lat; bit ok; int bad;
        axi_write(32'h40, 32'hCAFEF00D, 4'hF, resp, ok);
        total++;
        if (!ok || resp !== 2'b10) $display("FAIL oor_bresp: ok=%0d got %b want 10", ok, resp);
        else passed++;
        axi_read(32'h40, data, resp, lat, ok);
        total++;
        if (!ok || data !== 32'h0 || resp !== 2'b10)
            $display("FAIL oor_read: ok=%0d got %h/%b want 0/10", ok, data, resp);
        else passed++;
        bad = 0;
        for (int i = 0; i < NR; i++) begin
            axi_read(32'(i * 4), data, resp, lat, ok);
            if (!ok || data !== model[i]) bad++;
        end
        total++;
        if (bad != 0) $display("FAIL oor_regs_unchanged: %0d regs differ, want 0", bad);
        else passed++;
    endtask

    task automatic test_backpressure();
        int bad;
        logic [31:0] d;
        d = $urandom;
        @(negedge clk);
        bus.awaddr = 32'h10; bus.awvalid = 1'b1; bus.bready = 1'b0;
        bus.wdata = d; bus.wstrb = 4'hF;
        bad = 0;
        for (int i = 0; i < 3; i++) begin
            #1;
            if (bus.awready !== 1'b0 || bus.wready !== 1'b0) bad++;
            @(negedge clk);
        end
        total++;
        if (bad != 0) $display("FAIL aw_only_no_accept: %0d cycles with ready, want 0", bad);
        else passed++;
        bus.wvalid = 1'b1;
        #1;
        total++;
        if (bus.awready !== 1'b1 || bus.wready !== 1'b1)
            $display("FAIL joint_ready: got %b%b want 11", bus.awready, bus.wready);
        else passed++;
        @(posedge clk);
        #1;
        bus.awvalid = 1'b0; bus.wvalid = 1'b0;
        model_write(32'h10, d, 4'hF);
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (bus.bvalid !== 1'b1 || bus.bresp !== 2'b00 || bus.awready !== 1'b0) bad++;
        end
        total++;
        if (bad != 0) $display("FAIL bvalid_held: %0d bad cycles, want 0", bad);
        else passed++;
        bus.bready = 1'b1;
        @(posedge clk);
        #1;
        bus.bready = 1'b0;
        @(negedge clk);
        total++;
        if (bus.bvalid !== 1'b0) $display("FAIL bvalid_drop: got %b want 0", bus.bvalid);
        else passed++;
    endtask

    task automatic test_same_cycle();
        logic [1:0] wresp, rresp; logic [31:0] data; int lat; bit wok, rok;
        axi_write(32'h0C, 32'h11111111, 4'hF, wresp, wok);
        model_write(32'h0C, 32'h11111111, 4'hF);
        fork
            axi_write(32'h0C, 32'h22222222, 4'hF, wresp, wok);
            axi_read(32'h0C, data, rresp, lat, rok);
        join
        total++;
        if (!rok || data !== 32'h11111111)
            $display("FAIL same_cycle_old: got %h want 11111111", data);
        else passed++;
        model_write(32'h0C, 32'h22222222, 4'hF);
        axi_read(32'h0C, data, rresp, lat, rok);
        total++;
        if (!rok || data !== 32'h22222222)
            $display("FAIL same_cycle_new: got %h want 22222222", data);
        else passed++;
    endtask

    task automatic test_random();
        logic [1:0] resp; logic [31:0] data, addr, wd; logic [3:0] strb; int lat; bit ok;
        int bad_w, bad_r;
        bad_w = 0; bad_r = 0;
        for (int i = 0; i < 80; i++) begin
            addr = {28'($urandom_range(0, 19)), 2'($urandom)};
            if ($urandom_range(0, 1) == 1) begin
                wd = $urandom; strb = 4'($urandom);
                axi_write(addr, wd, strb, resp, ok);
                if (!ok || resp !== exp_resp(addr)) bad_w++;
                model_write(addr, wd, strb);
            end else begin
                axi_read(addr, data, resp, lat, ok);
                if (!ok || data !== exp_rdata(addr) || resp !== exp_resp(addr) || lat != 1)
                    bad_r++;
            end
        end
        total++;
        if (bad_w != 0) $display("FAIL random_writes: %0d wrong responses, want 0", bad_w);
        else passed++;
        total++;
        if (bad_r != 0) $display("FAIL random_reads: %0d wrong reads, want 0", bad_r);
        else passed++;
    endtask

    task automatic test_reset_mid_txn();
        logic [1:0] resp; logic [31:0] data; int lat; bit ok; int bad;
        @(negedge clk);
        bus.awaddr = 32'h00; bus.wdata = 32'hA5A5A5A5; bus.wstrb = 4'hF;
        bus.awvalid = 1'b1; bus.wvalid = 1'b1; bus.bready = 1'b0;
        bus.araddr = 32'h08; bus.arvalid = 1'b1; bus.rready = 1'b0;
        @(posedge clk);
        #1;
        bus.awvalid = 1'b0; bus.wvalid = 1'b0; bus.arvalid = 1'b0;
        @(negedge clk);
        total++;
        if (bus.bvalid !== 1'b1 || bus.rvalid !== 1'b1)
            $display("FAIL pre_reset_valids: got %b%b want 11", bus.bvalid, bus.rvalid);
        else passed++;
        rst = 1'b1;
        #1;
        total++;
        if (bus.bvalid !== 1'b0 || bus.rvalid !== 1'b0 || bus.rdata !== 32'h0)
            $display("FAIL reset_abort: bvalid=%b rvalid=%b rdata=%h want 0 0 0",
                     bus.bvalid, bus.rvalid, bus.rdata);
        else passed++;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < NR; i++) model[i] = 32'h0;
        bus.bready = 1'b1; bus.rready = 1'b1;
        bad = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (bus.bvalid !== 1'b0 || bus.rvalid !== 1'b0) bad++;
        end
        bus.bready = 1'b0; bus.rready = 1'b0;
        total++;
        if (bad != 0) $display("FAIL no_reissue: %0d cycles with a response, want 0", bad);
        else passed++;
        bad = 0;
        for (int i = 0; i < NR; i++) begin
            axi_read(32'(i * 4), data, resp, lat, ok);
            if (!ok || data !== model[i] || resp !== 2'b00) bad++;
        end
        total++;
        if (bad != 0) $display("FAIL post_reset_zero: %0d regs nonzero, want 0", bad);
        else passed++;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_strobes();
        test_out_of_range();
        test_backpressure();
        test_same_cycle();
        test_random();
        test_reset_mid_txn();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/axil_reg_slave.md
AXIL_REG_SLAVE -- requirements
Module: axil_reg_slave

Interface
REQ-001 Parameter ADDR_WIDTH, 32, AXI4-Lite address width.
REQ-002 Parameter DATA_WIDTH, 32, data width; fixed at 32 for this block.
REQ-003 Parameter STRB_WIDTH, 4, DATA_WIDTH/8 byte strobes.
REQ-004 Parameter NUM_REGS, 16, number of 32-bit registers; power of two, 2..256.
REQ-005 One clock; reset is asynchronous and active-high: clk input 1 system clock, rising edge; rst input 1 asynchronous active-high reset.
REQ-006 Write address: s_axil_awaddr in ADDR_WIDTH; s_axil_awprot in 3; s_axil_awvalid in 1; s_axil_awready out 1.
REQ-007 Write data: s_axil_wdata in DATA_WIDTH; s_axil_wstrb in STRB_WIDTH; s_axil_wvalid in 1; s_axil_wready out 1.
REQ-008 Write response: s_axil_bresp out 2; s_axil_bvalid out 1; s_axil_bready in 1.
REQ-009 Read address: s_axil_araddr in ADDR_WIDTH; s_axil_arprot in 3; s_axil_arvalid in 1; s_axil_arready out 1.
REQ-010 Read data: s_axil_rdata out DATA_WIDTH; s_axil_rresp out 2; s_axil_rvalid out 1; s_axil_rready in 1.

Function
REQ-011 Write FSM SHALL have states W_IDLE, W_RESP; read FSM SHALL have states R_IDLE, R_DATA; both FSMs independent.
REQ-012 In W_IDLE with awvalid=1 and wvalid=1, awready and wready SHALL both be 1 for exactly that one cycle (combinational from the valids and state); handshake completes at that edge; FSM -> W_RESP.
REQ-013 In W_IDLE with only one of awvalid/wvalid high, awready=wready=0; no partial acceptance.
REQ-014 In W_RESP, awready=wready=0; bvalid=1 with bresp held stable until bready=1; on bvalid&&bready FSM -> W_IDLE; next write accepted no earlier than the following cycle.
REQ-015 Word index = awaddr[ADDR_WIDTH-1:2]; awaddr[1:0] ignored; in range iff index < NUM_REGS.
REQ-016 In-range write SHALL update byte lane k of register[index] from wdata[8k+7:8k] iff wstrb[k]=1, at the handshake edge; bresp=2'b00 (OKAY). wstrb=0 is a legal no-op with OKAY.
REQ-017 Out-of-range write SHALL modify no register; bresp=2'b10 (SLVERR).
REQ-018 In R_IDLE with arvalid=1, arready SHALL be 1 for that cycle; FSM -> R_DATA; rdata/rresp registered at that edge; read latency 1 cycle (rvalid high the cycle after handshake).
REQ-019 In R_DATA, arready=0; rvalid=1, rdata and rresp held stable until rready=1; then -> R_IDLE.
REQ-020 In-range read: rdata=register[index], rresp=2'b00; out-of-range: rdata=0, rresp=2'b10.
REQ-021 Simultaneous write and read handshake on the same register in one cycle: read SHALL return the pre-write value.
REQ-022 awprot/arprot SHALL be ignored.
REQ-023 Once asserted, bvalid/rvalid SHALL not deassert before the matching ready.

Reset
REQ-024 While rst=1: both FSMs IDLE; all registers 0; awready=wready=arready=0; bvalid=rvalid=0; bresp=rresp=2'b00; rdata=0.
REQ-025 rst asserted mid-transaction SHALL abort it immediately; pending responses discarded and not reissued.
REQ-026 No handshake SHALL complete in the first cycle after rst deasserts is not required; slave SHALL accept from the first rising edge with rst=0.

Structure
REQ-027 Shared package axil_pkg SHALL hold RESP_OKAY=2'b00, RESP_SLVERR=2'b10, and the write/read state enum typedefs.
REQ-028 One sub-module axil_reg_bank SHALL hold the register array: one byte-strobed write port, one combinational read port, async reset to 0.
REQ-029 Block SHALL satisfy the team's existing AXI4-Lite protocol assertions (valid held until ready, stable address/data while valid) when bound to its ports.

Verification
REQ-030 Write awaddr=0x08, wdata=0xDEADBEEF, wstrb=0xF, then read 0x08 -> bresp=00; rdata=0xDEADBEEF, rresp=00, rvalid one cycle after arready.
REQ-031 Write 0x04 =0xFFFFFFFF, then 0x04 wdata=0x12345678 wstrb=0x5 -> read 0x04 returns 0xFF34FF78.
REQ-032 Write 0x40 (index 16, NUM_REGS=16) and read 0x40 -> bresp=10, rresp=10, rdata=0; registers unchanged.
REQ-033 awvalid held 3 cycles before wvalid rises -> awready/wready stay 0 until both valid, then pulse together; bready held low 5 cycles -> bvalid and bresp stable all 5 cycles.
REQ-034 Register 0x0C=0x11111111; same-cycle write 0x0C=0x22222222 and read 0x0C -> rdata=0x11111111; subsequent read 0x22222222.
REQ-035 Assert rst while bvalid=1 and rvalid=1 -> both drop with rst; after release, reads of all registers return 0.
